// File: rtl/riscv_pkg.sv
// Shared architectural constants and the fetch-queue entry layout.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetch-queue entry: the fetched word tagged with its address.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries, with flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_eff;
  logic             pop_eff;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign rdata     = mem[rd_ptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop_eff  = pop & not_empty;
  assign push_eff = push & (~full | pop_eff);

  // Pointer and occupancy tracking; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_eff && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC selection and a decoupling queue to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [XLEN-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);

  fetch_entry_t wr_entry;
  fetch_entry_t head;
  logic         q_full;
  logic         deq;
  logic         enq;
  logic [XLEN-1:0] pc_next;

  assign deq = out_valid & out_ready;
  assign enq = fetch_en & ~redirect_valid & (~q_full | deq);

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = instruction;

  // Next PC: redirect wins, otherwise advance only when a word was accepted.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc & ~XLEN'(3);
    end else if (enq) begin
      pc_next = pc + PC_INC;
    end
  end

  // PC register; pc is a pure register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (enq),
    .wdata     (wr_entry),
    .pop       (deq),
    .rdata     (head),
    .not_empty (out_valid),
    .full      (q_full)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
